// File: rtl/time_entry_buffer_pkg.sv
// Shared definitions for the cooking-timer entry front end: FSM encoding,
// keypad digit range and the default legal limit for the seconds-tens digit.
package time_entry_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_LOAD     = 2'd2,
        ST_WAIT_RUN = 2'd3
    } state_t;

    // Keypad codes above this are function keys and never enter the buffer.
    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

    // Seconds-tens above this cannot be loaded into the mod6 counter.
    localparam int MAX_SEC_TENS_DEF = 5;

endpackage

// File: rtl/time_entry_buffer_key_filter.sv
// Decides whether a keypress becomes a buffered digit: it must be a
// decimal digit, arrive while entry is allowed, and find room in the buffer.
module time_entry_buffer_key_filter
    import time_entry_buffer_pkg::*;
(
    input  logic       key_valid,
    input  logic [3:0] key,
    input  state_t     state,
    input  logic       buffer_full,
    output logic       key_accept
);

    logic is_digit;
    logic entry_allowed;

    assign is_digit      = (key <= KEY_MAX_DIGIT);
    assign entry_allowed = (state == ST_IDLE) || (state == ST_ENTRY);
    assign key_accept    = key_valid && is_digit && entry_allowed && !buffer_full;

endmodule

// File: rtl/time_entry_buffer.sv
// Keypad entry buffer in front of the M:SS counter chain. Digits shift in
// from the right; a valid start emits a one-cycle active-low load pulse and
// the block then waits for the timer to finish before accepting new entry.
module time_entry_buffer
    import time_entry_buffer_pkg::*;
#(
    parameter int MAX_DIGITS   = 3,
    parameter int MAX_SEC_TENS = MAX_SEC_TENS_DEF
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       start,
    input  logic       clear,
    input  logic       running,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       loadn,
    output logic       entry_active,
    output logic       error
);

    localparam int            CW           = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] COUNT_MAX    = CW'(MAX_DIGITS);
    localparam logic [3:0]    SEC_TENS_LIM = 4'(MAX_SEC_TENS);

    state_t        state_q;
    logic [3:0]    min_ones_q;
    logic [3:0]    sec_tens_q;
    logic [3:0]    sec_ones_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          loadn_q;
    logic          entry_q;
    logic          error_q;
    logic          running_dly_q;

    logic          buffer_full;
    logic          key_accept;
    logic          digits_nonzero;
    logic          start_ok;
    logic          run_done;

    time_entry_buffer_key_filter u_key_filter (
        .key_valid   (key_valid),
        .key         (key),
        .state       (state_q),
        .buffer_full (buffer_full),
        .key_accept  (key_accept)
    );

    assign buffer_full    = (count_q == COUNT_MAX);
    assign count_d        = buffer_full ? count_q : count_q + 1'b1;
    assign digits_nonzero = (min_ones_q != 4'd0) || (sec_tens_q != 4'd0) || (sec_ones_q != 4'd0);
    // A start only acts when the timer is idle and there is something to load.
    assign start_ok       = !running && digits_nonzero;
    // Timer finished: running seen high last cycle, low now.
    assign run_done       = running_dly_q && !running;

    // Entry FSM, shift buffer and registered outputs; clear beats start beats key.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q       <= ST_IDLE;
            min_ones_q    <= 4'd0;
            sec_tens_q    <= 4'd0;
            sec_ones_q    <= 4'd0;
            count_q       <= '0;
            loadn_q       <= 1'b1;
            entry_q       <= 1'b0;
            error_q       <= 1'b0;
            running_dly_q <= 1'b0;
        end else begin
            running_dly_q <= running;
            loadn_q       <= 1'b1;
            if (clear) begin
                state_q    <= ST_IDLE;
                min_ones_q <= 4'd0;
                sec_tens_q <= 4'd0;
                sec_ones_q <= 4'd0;
                count_q    <= '0;
                error_q    <= 1'b0;
                entry_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_ENTRY: begin
                        if (start) begin
                            // Any keypress in the same cycle is dropped.
                            if (start_ok) begin
                                if (sec_tens_q > SEC_TENS_LIM) begin
                                    error_q <= 1'b1;
                                end else begin
                                    state_q <= ST_LOAD;
                                    loadn_q <= 1'b0;
                                    entry_q <= 1'b0;
                                end
                            end
                        end else if (key_accept) begin
                            min_ones_q <= sec_tens_q;
                            sec_tens_q <= sec_ones_q;
                            sec_ones_q <= key;
                            count_q    <= count_d;
                            error_q    <= 1'b0;
                            state_q    <= ST_ENTRY;
                            entry_q    <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        state_q <= ST_WAIT_RUN;
                    end
                    ST_WAIT_RUN: begin
                        if (run_done) begin
                            state_q    <= ST_IDLE;
                            min_ones_q <= 4'd0;
                            sec_tens_q <= 4'd0;
                            sec_ones_q <= 4'd0;
                            count_q    <= '0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign min_ones     = min_ones_q;
    assign sec_tens     = sec_tens_q;
    assign sec_ones     = sec_ones_q;
    assign loadn        = loadn_q;
    assign entry_active = entry_q;
    assign error        = error_q;

endmodule

// File: tb/tb_time_entry_buffer.sv
// Directed bench for time_entry_buffer: a cycle-by-cycle vector table with
// hand-computed outputs, plus sequences for asynchronous reset during load.
module tb_time_entry_buffer;

    logic       clock = 1'b0;
    logic       clr;
    logic       key_valid;
    logic [3:0] key;
    logic       start;
    logic       clear;
    logic       running;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       loadn;
    logic       entry_active;
    logic       error;

    int errors = 0;
    int checks = 0;

    time_entry_buffer dut (
        .clock        (clock),
        .clr          (clr),
        .key_valid    (key_valid),
        .key          (key),
        .start        (start),
        .clear        (clear),
        .running      (running),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .loadn        (loadn),
        .entry_active (entry_active),
        .error        (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       clear;
        logic       start;
        logic       kv;
        logic [3:0] key;
        logic       run;
        logic [3:0] e_min;
        logic [3:0] e_tens;
        logic [3:0] e_ones;
        logic       e_loadn;
        logic       e_entry;
        logic       e_err;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add(input logic cl, input logic st, input logic kv, input logic [3:0] k,
                       input logic run, input logic [3:0] em, input logic [3:0] et,
                       input logic [3:0] eo, input logic ld, input logic ea, input logic er);
        vecs[nvec] = '{cl, st, kv, k, run, em, et, eo, ld, ea, er};
        nvec++;
    endtask

    task automatic check(input string name, input logic [3:0] em, input logic [3:0] et,
                         input logic [3:0] eo, input logic ld, input logic ea, input logic er);
        logic [14:0] act;
        logic [14:0] exp;
        act = {min_ones, sec_tens, sec_ones, loadn, entry_active, error};
        exp = {em, et, eo, ld, ea, er};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got digits=%0h:%0h%0h loadn=%b entry=%b err=%b, expected digits=%0h:%0h%0h loadn=%b entry=%b err=%b",
                     name, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                     em, et, eo, ld, ea, er);
        end else begin
            $display("ok   %s: digits=%0h:%0h%0h loadn=%b entry=%b err=%b",
                     name, min_ones, sec_tens, sec_ones, loadn, entry_active, error);
        end
    endtask

    task automatic idle_inputs();
        clear = 0; start = 0; key_valid = 0; key = 4'd0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clr = 1'b1;
        running = 1'b0;
        idle_inputs();

        //   cl st kv key run  min tens ones loadn ent err
        add(0, 0, 0, 4'd0,  0, 0, 0, 0, 1, 0, 0); // idle after reset
        add(0, 0, 1, 4'd1,  0, 0, 0, 1, 1, 1, 0); // key 1
        add(0, 0, 1, 4'd3,  0, 0, 1, 3, 1, 1, 0); // key 3
        add(0, 0, 1, 4'd0,  0, 1, 3, 0, 1, 1, 0); // key 0 -> 1:30
        add(0, 1, 0, 4'd0,  0, 1, 3, 0, 0, 0, 0); // start -> LOAD pulse
        add(0, 0, 0, 4'd0,  0, 1, 3, 0, 1, 0, 0); // WAIT_RUN, pulse ended
        add(0, 0, 0, 4'd0,  1, 1, 3, 0, 1, 0, 0); // timer running
        add(0, 0, 1, 4'd5,  1, 1, 3, 0, 1, 0, 0); // key ignored while running
        add(0, 1, 0, 4'd0,  1, 1, 3, 0, 1, 0, 0); // start ignored in WAIT_RUN
        add(0, 0, 0, 4'd0,  0, 0, 0, 0, 1, 0, 0); // running fell -> IDLE, 0:00
        add(0, 0, 1, 4'd9,  0, 0, 0, 9, 1, 1, 0); // key 9
        add(0, 0, 1, 4'd5,  0, 0, 9, 5, 1, 1, 0); // key 5
        add(0, 0, 1, 4'd2,  0, 9, 5, 2, 1, 1, 0); // key 2 -> 9:52 full
        add(0, 0, 1, 4'd7,  0, 9, 5, 2, 1, 1, 0); // fourth key ignored
        add(1, 0, 0, 4'd0,  0, 0, 0, 0, 1, 0, 0); // clear
        add(0, 0, 1, 4'd11, 0, 0, 0, 0, 1, 0, 0); // non-digit key ignored
        add(0, 1, 0, 4'd0,  0, 0, 0, 0, 1, 0, 0); // start with empty buffer
        add(0, 0, 1, 4'd0,  0, 0, 0, 0, 1, 1, 0); // key 0 accepted
        add(0, 0, 1, 4'd7,  0, 0, 0, 7, 1, 1, 0); // key 7
        add(0, 0, 1, 4'd0,  0, 0, 7, 0, 1, 1, 0); // key 0 -> 0:70
        add(0, 1, 0, 4'd0,  0, 0, 7, 0, 1, 1, 1); // start -> error, no pulse
        add(0, 0, 1, 4'd4,  0, 0, 7, 0, 1, 1, 1); // full, error sticky
        add(1, 0, 0, 4'd0,  0, 0, 0, 0, 1, 0, 0); // clear drops error
        add(0, 1, 1, 4'd4,  0, 0, 0, 0, 1, 0, 0); // start+key on empty: key dropped
        add(0, 0, 1, 4'd2,  0, 0, 0, 2, 1, 1, 0); // key 2
        add(0, 1, 1, 4'd8,  0, 0, 0, 2, 0, 0, 0); // start+key: load 0:02, key dropped
        add(0, 0, 0, 4'd0,  0, 0, 0, 2, 1, 0, 0); // WAIT_RUN
        add(1, 0, 0, 4'd0,  0, 0, 0, 0, 1, 0, 0); // clear exits WAIT_RUN
        add(0, 0, 1, 4'd8,  0, 0, 0, 8, 1, 1, 0); // key 8
        add(0, 0, 1, 4'd0,  0, 0, 8, 0, 1, 1, 0); // key 0 -> 0:80
        add(0, 1, 0, 4'd0,  0, 0, 8, 0, 1, 1, 1); // start -> error
        add(0, 0, 1, 4'd1,  0, 8, 0, 1, 1, 1, 0); // digit accepted clears error
        add(0, 1, 0, 4'd0,  1, 8, 0, 1, 1, 1, 0); // start ignored, running high
        add(0, 0, 0, 4'd0,  0, 8, 0, 1, 1, 1, 0); // running fall outside WAIT_RUN
        add(0, 0, 1, 4'd6,  0, 8, 0, 1, 1, 1, 0); // full again, ignored

        // reset state while clr held and after release
        repeat (2) @(posedge clock);
        #1;
        check("reset_held", 0, 0, 0, 1, 0, 0);
        clr = 1'b0;
        step();
        check("reset_release", 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < nvec; i++) begin
            clear     = vecs[i].clear;
            start     = vecs[i].start;
            key_valid = vecs[i].kv;
            key       = vecs[i].key;
            running   = vecs[i].run;
            step();
            check($sformatf("vec%0d", i), vecs[i].e_min, vecs[i].e_tens, vecs[i].e_ones,
                  vecs[i].e_loadn, vecs[i].e_entry, vecs[i].e_err);
        end

        // asynchronous reset during the LOAD cycle
        idle_inputs();
        running = 1'b0;
        clear = 1'b1;
        step();
        idle_inputs();
        key_valid = 1; key = 4'd4;
        step();
        key_valid = 0; start = 1;
        step();
        start = 0;
        check("load_pulse", 0, 0, 4, 0, 0, 0);
        #2 clr = 1'b1;
        #1;
        check("clr_mid_load", 0, 0, 0, 1, 0, 0);
        step();
        check("clr_held_edge", 0, 0, 0, 1, 0, 0);
        clr = 1'b0;
        step();
        check("after_clr", 0, 0, 0, 1, 0, 0);

        // start on empty buffer after reset produces no pulse
        start = 1;
        step();
        start = 0;
        check("empty_start", 0, 0, 0, 1, 0, 0);
        step();
        check("empty_start_next", 0, 0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
